// File: rtl/seg_scan_capture_pkg.sv
// seg_scan_pkg: shared character codes, seven-segment patterns and FSM
// encoding for the seven-segment scan monitor. The code constants here are
// also the reference for the display-side character mapping.
package seg_scan_pkg;

  // character codes
  localparam logic [3:0] ONE      = 4'h0;
  localparam logic [3:0] LETTER_O = 4'h1;
  localparam logic [3:0] LETTER_P = 4'h2;
  localparam logic [3:0] LETTER_R = 4'h3;
  localparam logic [3:0] BLANK    = 4'hE;
  localparam logic [3:0] UNKNOWN  = 4'hF;

  // active-low segment patterns, bit6..bit0 = a..g
  localparam logic [6:0] PAT_ONE   = 7'b1001111;
  localparam logic [6:0] PAT_O     = 7'b1100010;
  localparam logic [6:0] PAT_P     = 7'b0011000;
  localparam logic [6:0] PAT_R     = 7'b1111010;
  localparam logic [6:0] PAT_BLANK = 7'b1111111;

  // capture FSM encoding
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] HELD   = 2'd2;

  // one sampled anode/segment pair
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } scan_pair_t;

endpackage

// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if: display scan lines in, decoded frame out.
//   an/seg        : active-low anode / segment lines (driven by master)
//   chars         : captured 4-character frame
//   frame_valid   : one-cycle strobe when chars updates
//   frame_unknown : frame held at least one UNKNOWN digit
//   overlap_err   : one-cycle pulse per overlapping-anode cycle
interface seg_scan_capture_if;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] chars;
  logic        frame_valid;
  logic        frame_unknown;
  logic        overlap_err;

  modport master (output an, seg, input chars, frame_valid, frame_unknown, overlap_err);
  modport slave  (input an, seg, output chars, frame_valid, frame_unknown, overlap_err);
endinterface

// File: rtl/seg_pattern_decode.sv
// seg_pattern_decode: combinational seven-segment pattern -> character code.
//   seg  : active-low segment pattern (a..g on bit6..bit0)
//   code : character code, UNKNOWN for any unlisted pattern
module seg_pattern_decode
  import seg_scan_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] code
);

  always_comb begin
    code = UNKNOWN;
    case (seg)
      PAT_ONE:   code = ONE;
      PAT_O:     code = LETTER_O;
      PAT_P:     code = LETTER_P;
      PAT_R:     code = LETTER_R;
      PAT_BLANK: code = BLANK;
      default:   code = UNKNOWN;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed 4-digit seven-segment scan,
// decodes each settled digit and publishes complete 4-character frames.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of seg_scan_capture_if (an/seg in, frame out)
module seg_scan_capture
  import seg_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int SYNC_STAGES   = 2
)(
  input  logic                clk,
  input  logic                reset_n,
  seg_scan_capture_if.slave   bus
);

  localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYCLES);

  // input synchronizer, idles at all-ones (nothing lit)
  scan_pair_t [SYNC_STAGES-1:0] sync_q;
  scan_pair_t                   pair_s, pair_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '1;
      pair_p <= '1;
    end else begin
      sync_q[0] <= {bus.an, bus.seg};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      pair_p <= pair_s;
    end
  end

  assign pair_s = sync_q[SYNC_STAGES-1];

  // anode classification
  logic       one_low, is_idle, is_ovl;
  logic [1:0] idx;

  always_comb begin
    one_low = 1'b0;
    idx     = 2'd0;
    case (pair_s.an)
      4'b1110: begin one_low = 1'b1; idx = 2'd0; end
      4'b1101: begin one_low = 1'b1; idx = 2'd1; end
      4'b1011: begin one_low = 1'b1; idx = 2'd2; end
      4'b0111: begin one_low = 1'b1; idx = 2'd3; end
      default: ;
    endcase
  end

  assign is_idle = (pair_s.an == 4'hF);
  assign is_ovl  = !one_low && !is_idle;

  logic [3:0] code;
  seg_pattern_decode u_dec (.seg(pair_s.seg), .code(code));

  // settle FSM; cnt counts consecutive cycles the current pair has been seen
  logic [1:0] state;
  logic [7:0] cnt;
  logic       changed, capture;

  assign changed = (pair_s != pair_p);
  assign capture = (state == SETTLE) && !changed && (cnt == SETTLE_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (one_low) begin
            state <= SETTLE;
            cnt   <= 8'd1;
          end
        end
        SETTLE: begin
          if (changed) begin
            if (one_low) cnt <= 8'd1;
            else         state <= IDLE;
          end else if (cnt == SETTLE_MAX) begin
            state <= HELD;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        HELD: begin
          // any change (new anode or new pattern on same anode) re-settles
          if (changed) begin
            if (one_low) begin
              state <= SETTLE;
              cnt   <= 8'd1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // per-digit capture and frame assembly
  logic [3:0]       hit, seen, unk, seen_nxt, unk_nxt;
  logic [3:0][3:0]  digit_q, dig_nxt;
  logic             frame_done;
  logic [15:0]      chars_q;
  logic             fv_q, funk_q, ovl_q;

  assign hit      = capture ? (4'b0001 << idx) : 4'b0000;
  assign seen_nxt = seen | hit;
  assign unk_nxt  = (unk & ~hit) | ((code == UNKNOWN) ? hit : 4'b0000);

  // dig_nxt folds the just-captured digit into the frame image
  always_comb begin
    for (int k = 0; k < 4; k++) dig_nxt[k] = hit[k] ? code : digit_q[k];
  end

  assign frame_done = capture && (seen_nxt == 4'hF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_q <= '0;
      seen    <= '0;
      unk     <= '0;
      chars_q <= '0;
      fv_q    <= 1'b0;
      funk_q  <= 1'b0;
      ovl_q   <= 1'b0;
    end else begin
      digit_q <= dig_nxt;
      fv_q    <= frame_done;
      ovl_q   <= is_ovl;
      if (frame_done) begin
        chars_q <= dig_nxt;
        funk_q  <= |unk_nxt;
        seen    <= '0;
        unk     <= '0;
      end else begin
        seen    <= seen_nxt;
        unk     <= unk_nxt;
      end
    end
  end

  assign bus.chars         = chars_q;
  assign bus.frame_valid   = fv_q;
  assign bus.frame_unknown = funk_q;
  assign bus.overlap_err   = ovl_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed + random scans against a run-length model:
// a valid-anode pair held for >= SETTLE+1 raw cycles yields one capture.
module tb_seg_scan_capture;

  localparam int SETTLE = 4;
  localparam int SYNC   = 2;
  localparam int FLUSH  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_capture_if bus();

  seg_scan_capture #(.SETTLE_CYCLES(SETTLE), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_vec = 0, n_err = 0;

  // observed side
  logic [15:0] obs_c[$];
  logic        obs_u[$];
  int          obs_ovl = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.frame_valid) begin
        obs_c.push_back(bus.chars);
        obs_u.push_back(bus.frame_unknown);
      end
      if (bus.overlap_err) obs_ovl++;
    end
  end

  // reference model
  logic [6:0]  pat [4] = '{7'b1001111, 7'b1100010, 7'b0011000, 7'b1111010};
  logic [3:0]  m_an = 4'hF;
  logic [6:0]  m_seg = 7'h7F;
  int          m_len = 0;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_seen = '0, m_unk = '0;
  logic [15:0] m_chars = '0;
  logic        m_funk = 1'b0;
  logic [15:0] exp_c[$];
  logic        exp_u[$];
  int          exp_ovl = 0;
  int          nchk = 0;

  function automatic logic [3:0] ref_code(logic [6:0] s);
    case (s)
      7'b1001111: return 4'h0;
      7'b1100010: return 4'h1;
      7'b0011000: return 4'h2;
      7'b1111010: return 4'h3;
      7'b1111111: return 4'hE;
      default:    return 4'hF;
    endcase
  endfunction

  function automatic int an_idx(logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // close the current run: long-enough valid runs capture one digit
  task automatic fin();
    int k;
    logic [3:0] c;
    k = an_idx(m_an);
    if (k >= 0 && m_len >= SETTLE + 1) begin
      c = ref_code(m_seg);
      m_dig[k]  = c;
      m_seen[k] = 1'b1;
      m_unk[k]  = (c == 4'hF);
      if (m_seen == 4'hF) begin
        m_chars = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        m_funk  = |m_unk;
        exp_c.push_back(m_chars);
        exp_u.push_back(m_funk);
        m_seen = '0;
        m_unk  = '0;
      end
    end
  endtask

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    if (a !== m_an || s !== m_seg) begin
      fin();
      m_an  = a;
      m_seg = s;
      m_len = 0;
    end
    m_len += n;
    if (a != 4'hF && an_idx(a) < 0) exp_ovl += n;
    bus.an  = a;
    bus.seg = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic dig(input int k, input logic [6:0] s, input int n);
    drive(~(4'b0001 << k), s, n);
  endtask

  // scan digit0..3 with the given patterns
  task automatic scan(input logic [6:0] s0, s1, s2, s3, input int n);
    dig(0, s0, n); dig(1, s1, n); dig(2, s2, n); dig(3, s3, n);
  endtask

  task automatic check_frames(input string tag);
    int lim;
    drive(4'hF, 7'h7F, FLUSH);
    chk({tag, "_nframes"}, 32'(obs_c.size()), 32'(exp_c.size()));
    lim = (obs_c.size() < exp_c.size()) ? obs_c.size() : exp_c.size();
    for (int i = nchk; i < lim; i++) begin
      chk({tag, "_chars"}, 32'(obs_c[i]), 32'(exp_c[i]));
      chk({tag, "_unk"},   32'(obs_u[i]), 32'(exp_u[i]));
    end
    nchk = lim;
    chk({tag, "_ovl"},        32'(obs_ovl), 32'(exp_ovl));
    chk({tag, "_chars_hold"}, 32'(bus.chars), 32'(m_chars));
    chk({tag, "_funk_hold"},  32'(bus.frame_unknown), 32'(m_funk));
  endtask

  task automatic do_reset(input string tag);
    drive(4'hF, 7'h7F, FLUSH);
    reset_n = 1'b0;
    #1;
    chk({tag, "_rst_chars"}, 32'(bus.chars), 32'h0);
    chk({tag, "_rst_fv"},    32'(bus.frame_valid), 32'h0);
    chk({tag, "_rst_funk"},  32'(bus.frame_unknown), 32'h0);
    chk({tag, "_rst_ovl"},   32'(bus.overlap_err), 32'h0);
    m_seen  = '0;
    m_unk   = '0;
    m_chars = '0;
    m_funk  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  localparam logic [6:0] P1 = 7'b1001111, PO = 7'b1100010, PP = 7'b0011000, PR = 7'b1111010;

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int r;
    bus.an  = 4'hF;
    bus.seg = 7'h7F;
    @(posedge clk);
    #1;
    do_reset("init");

    // basic frame "1oPr"
    scan(PR, PP, PO, P1, SETTLE + 3);
    check_frames("basic");
    chk("basic_lit", 32'(bus.chars), 32'h0123);

    // too short, then just long enough
    scan(PR, PP, PO, P1, SETTLE - 1);
    check_frames("short");
    scan(PP, PR, P1, PO, SETTLE + 1);
    check_frames("minlen");

    // all segments lit on digit2 -> UNKNOWN
    scan(PR, PP, 7'b0000000, P1, SETTLE + 3);
    check_frames("unknown");
    chk("unknown_nib", 32'(bus.chars[11:8]), 32'hF);

    // single overlap cycle interrupts digit1, then rescan digit1
    dig(0, PR, SETTLE + 3);
    dig(1, PP, 2);
    drive(4'b1100, PP, 1);
    dig(2, PO, SETTLE + 3);
    dig(3, P1, SETTLE + 3);
    check_frames("ovl_part");
    dig(1, PP, SETTLE + 3);
    check_frames("ovl_done");

    // reset after 3 digits, one more digit, then a full rescan
    dig(0, PR, SETTLE + 3); dig(1, PP, SETTLE + 3); dig(2, PO, SETTLE + 3);
    do_reset("mid");
    dig(3, P1, SETTLE + 3);
    check_frames("post_rst");
    scan(P1, PO, PR, PP, SETTLE + 3);
    check_frames("rescan");

    // segment change on a held anode recaptures that digit
    dig(0, PR, SETTLE + 3);
    dig(1, PO, SETTLE + 3);
    dig(1, PP, SETTLE + 3);
    dig(2, PO, SETTLE + 3);
    dig(3, P1, SETTLE + 3);
    check_frames("recap");
    chk("recap_nib", 32'(bus.chars[7:4]), 32'h2);

    // random scans
    for (int round = 0; round < 4; round++) begin
      for (int step = 0; step < 40; step++) begin
        r = $urandom_range(0, 9);
        if (r <= 6)      a = ~(4'b0001 << $urandom_range(0, 3));
        else if (r == 7) a = 4'hF;
        else begin
          a = 4'($urandom_range(0, 15));
          if ($countones(a) >= 3) a = 4'b1010;
        end
        r = $urandom_range(0, 5);
        if (r <= 3)      s = pat[r];
        else if (r == 4) s = 7'h7F;
        else             s = 7'($urandom_range(0, 127));
        drive(a, s, $urandom_range(1, SETTLE + 3));
      end
      check_frames("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side monitor for the multiplexed 4-digit seven-segment interface.
- Samples the active-low anode and segment lines that the display driver produces.
- Decodes each lit digit's segment pattern back into its 4-bit character code.
- Publishes a complete 4-character frame with a one-cycle valid strobe; used for on-board self-check and bench scoreboarding of the "1oPr" display path.

Parameters:
- SETTLE_CYCLES, 4: consecutive cycles the anode+segment pair must stay unchanged before it is sampled (range 1..255).
- SYNC_STAGES, 2: flip-flop synchronizer depth on an/seg inputs (range 2..3).

Ports:
- clk  input  1  system clock; every register is clocked on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- an  input  4  anode lines, active-low; an[0] is the rightmost digit (digit0).
- seg  input  7  segment lines, active-low; bit6..bit0 = a,b,c,d,e,f,g.
- chars  output  16  captured frame; chars[4k+3:4k] = code of digit k.
- frame_valid  output  1  one-cycle pulse when chars is updated.
- frame_unknown  output  1  qualified by frame_valid: at least one digit in the frame decoded to UNKNOWN.
- overlap_err  output  1  one-cycle pulse per cycle in which more than one anode is low.

Behaviour:
- Reset values (reset_n low, asynchronous): chars=16'h0000, frame_valid=0, frame_unknown=0, overlap_err=0, state=IDLE, seen=4'b0000, settle counter=0, synchronizers=all ones.
- Inputs pass through SYNC_STAGES flops. All timing below refers to the synchronized values an_s and seg_s.
- Character codes (shared package):
  - ONE=4'h0, pattern 7'b1001111
  - LETTER_O=4'h1, pattern 7'b1100010
  - LETTER_P=4'h2, pattern 7'b0011000
  - LETTER_R=4'h3, pattern 7'b1111010
  - BLANK=4'hE, pattern 7'b1111111
  - UNKNOWN=4'hF, any other pattern
- Anode classification:
  - Exactly one bit of an_s low: valid digit, index = position of the low bit.
  - an_s==4'b1111: idle.
  - Otherwise: overlap.
- State machine:
  - IDLE: valid digit -> SETTLE, counter=1. Idle or overlap -> stay.
  - SETTLE: an_s/seg_s differ from the previous cycle -> restart. Restart means counter=1 if the digit is still valid, or go to IDLE if it is not. Counter==SETTLE_CYCLES -> capture, then go to HELD. Otherwise counter+1.
  - HELD: no re-capture while the pair is unchanged. Any change in an_s -> SETTLE for the new digit, or IDLE if not valid. A change in seg_s with the same anode -> SETTLE; a later capture overwrites that digit.
- Capture:
  - digit_reg[idx] <= decode(seg_s); seen[idx] <= 1; unk[idx] <= (code==UNKNOWN).
  - Capture occurs on the cycle after the pair has been stable for SETTLE_CYCLES cycles. Latency from raw input change to capture is SYNC_STAGES+SETTLE_CYCLES cycles.
- Frame:
  - The cycle after a capture that makes seen==4'b1111: chars <= all four digit_regs (including the just-captured digit), frame_unknown <= |unk, frame_valid=1 for exactly one cycle, seen and unk cleared.
  - A repeated capture of an already-seen digit before the frame completes overwrites that digit and does not advance the frame.
- overlap_err: registered, asserted one cycle after each synchronized cycle in which the anode pattern is classified as overlap. An overlap aborts any SETTLE in progress; seen bits are kept.
- Reset asserted mid-frame: all partial captures are discarded and no frame_valid is produced.
- chars holds its value between frames; frame_unknown holds until the next frame.

Decomposition:
- Package seg_scan_pkg:
  - character code constants ONE, LETTER_O, LETTER_P, LETTER_R, BLANK, UNKNOWN
  - the matching 7-bit segment pattern constants
  - the state encoding IDLE/SETTLE/HELD
  - the same code constants are the authority for the display-side character mapping
- One sub-module, seg_pattern_decode: purely combinational seg[6:0] -> 4-bit code lookup, reused by the bench scoreboard.

Test Plan:
- Scan an=1110/1101/1011/0111 with seg = r,P,o,1 patterns, SETTLE_CYCLES+3 cycles per digit -> one frame_valid, chars=16'h0123, frame_unknown=0.
- Hold each digit only SETTLE_CYCLES-1 cycles -> no capture and no frame_valid; then lengthen to SETTLE_CYCLES+1 -> frame produced.
- Digit2 seg=7'b0000000 (all on) -> chars[11:8]=4'hF, frame_unknown=1 on the frame_valid cycle.
- Drive an=1100 for 1 cycle mid-scan -> overlap_err pulses once; interrupted digit not captured; frame completes after a rescan of that digit with correct chars.
- Assert reset_n low after 3 digits captured, release, scan one more digit -> no frame_valid; full rescan -> frame_valid with chars exactly matching the rescan.
- Change seg from 'o' to 'P' while an=1101 held -> digit1 recaptured as 4'h2; the next frame shows chars[7:4]=4'h2.
